// File: rtl/phys_reg_free_list.sv
// Physical register free list for the 2-wide rename stage.
// Circular FIFO of free pregs with checkpointable head pointer.
module phys_reg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int NUM_FREE  = 2,
  localparam int IW = $clog2(NUM_PREGS),
  localparam int PW = IW + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    alloc_req,
  input  logic                          ext_stall,
  output logic                          alloc_ok,
  output logic [1:0][IW-1:0]            alloc_addr,
  input  logic [NUM_FREE-1:0]           free_valid,
  input  logic [NUM_FREE-1:0][IW-1:0]   free_addr,
  input  logic                          if_recall,
  input  logic [PW-1:0]                 recall_head,
  output logic [PW-1:0]                 head_ptr,
  output logic [PW-1:0]                 free_count,
  output logic                          overflow_err
);

  logic [IW-1:0] fifo [NUM_PREGS];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [1:0]    nreq;
  logic          commit;

  logic [NUM_FREE-1:0]          wr_en;
  logic [NUM_FREE-1:0][IW-1:0]  wr_idx;
  logic [PW-1:0]                rel_cnt;
  logic                         rel_drop;

  assign free_count = tail - head;
  assign head_ptr   = head;

  always_comb begin
    nreq = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
    alloc_ok = free_count >= PW'(nreq);
    alloc_addr[0] = fifo[head[IW-1:0]];
    alloc_addr[1] = fifo[head[IW-1:0] + IW'(alloc_req[0])];
    commit = alloc_ok & ~ext_stall & ~if_recall;
  end

  // Pack valid releases at the tail in port order; drop what won't fit.
  always_comb begin
    rel_cnt  = '0;
    rel_drop = 1'b0;
    wr_en    = '0;
    wr_idx   = '0;
    for (int j = 0; j < NUM_FREE; j++) begin
      wr_idx[j] = tail[IW-1:0] + rel_cnt[IW-1:0];
      if (free_valid[j]) begin
        if (free_count + rel_cnt < PW'(NUM_PREGS)) begin
          wr_en[j] = 1'b1;
          rel_cnt  = rel_cnt + PW'(1);
        end else begin
          rel_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= PW'(NUM_AREGS);
      overflow_err <= 1'b0;
      for (int i = 0; i < NUM_PREGS; i++)
        fifo[i] <= (i < NUM_AREGS) ? IW'(i + NUM_AREGS) : '0;
    end else begin
      for (int j = 0; j < NUM_FREE; j++)
        if (wr_en[j])
          fifo[wr_idx[j]] <= free_addr[j];
      tail <= tail + rel_cnt;
      if (rel_drop)
        overflow_err <= 1'b1;
      if (if_recall)
        head <= recall_head;
      else if (commit)
        head <= head + PW'(nreq);
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list.
// Each task drives one scenario and checks inline.
module tb_phys_reg_free_list;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      alloc_req;
  logic            ext_stall;
  logic            alloc_ok;
  logic [1:0][5:0] alloc_addr;
  logic [1:0]      free_valid;
  logic [1:0][5:0] free_addr;
  logic            if_recall;
  logic [6:0]      recall_head;
  logic [6:0]      head_ptr;
  logic [6:0]      free_count;
  logic            overflow_err;

  int errors = 0;
  int checks = 0;

  phys_reg_free_list dut (
    .clk(clk),
    .reset(reset),
    .alloc_req(alloc_req),
    .ext_stall(ext_stall),
    .alloc_ok(alloc_ok),
    .alloc_addr(alloc_addr),
    .free_valid(free_valid),
    .free_addr(free_addr),
    .if_recall(if_recall),
    .recall_head(recall_head),
    .head_ptr(head_ptr),
    .free_count(free_count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    alloc_req   = 2'b00;
    ext_stall   = 1'b0;
    free_valid  = 2'b00;
    free_addr   = '0;
    if_recall   = 1'b0;
    recall_head = '0;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic drain();
    alloc_req = 2'b11;
    repeat (16) step();
    clear_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (free_count !== 7'd32) begin
      errors++;
      $display("FAIL reset_count got %0d exp 32", free_count);
    end
    checks++;
    if (head_ptr !== 7'd0) begin
      errors++;
      $display("FAIL reset_head got %0d exp 0", head_ptr);
    end
    checks++;
    if (overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %0b exp 0", overflow_err);
    end
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_ok !== 1'b1 || alloc_addr[0] !== 6'd32 || alloc_addr[1] !== 6'd33) begin
      errors++;
      $display("FAIL first_alloc got ok=%0b %0d/%0d exp ok=1 32/33",
               alloc_ok, alloc_addr[0], alloc_addr[1]);
    end
    step();
    checks++;
    if (head_ptr !== 7'd2 || free_count !== 7'd30) begin
      errors++;
      $display("FAIL first_adv got head=%0d cnt=%0d exp 2/30", head_ptr, free_count);
    end
    clear_inputs();
  endtask

  task automatic test_drain();
    do_reset();
    alloc_req = 2'b11;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++;
      if (alloc_ok !== 1'b1 || alloc_addr[0] !== 6'(32 + 2 * k) ||
          alloc_addr[1] !== 6'(33 + 2 * k)) begin
        errors++;
        $display("FAIL drain_%0d got ok=%0b %0d/%0d exp ok=1 %0d/%0d", k,
                 alloc_ok, alloc_addr[0], alloc_addr[1], 32 + 2 * k, 33 + 2 * k);
      end
      step();
    end
    checks++;
    if (free_count !== 7'd0 || head_ptr !== 7'd32) begin
      errors++;
      $display("FAIL drain_end got cnt=%0d head=%0d exp 0/32", free_count, head_ptr);
    end
    #1;
    checks++;
    if (alloc_ok !== 1'b0) begin
      errors++;
      $display("FAIL empty_dual_ok got %0b exp 0", alloc_ok);
    end
    step();
    checks++;
    if (head_ptr !== 7'd32) begin
      errors++;
      $display("FAIL empty_hold got %0d exp 32", head_ptr);
    end
    alloc_req = 2'b00;
    #1;
    checks++;
    if (alloc_ok !== 1'b1) begin
      errors++;
      $display("FAIL empty_noreq_ok got %0b exp 1", alloc_ok);
    end
    clear_inputs();
  endtask

  task automatic test_one_free();
    do_reset();
    drain();
    // release and request together: release not yet allocatable
    free_valid   = 2'b01;
    free_addr[0] = 6'd7;
    alloc_req    = 2'b01;
    #1;
    checks++;
    if (alloc_ok !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_rel_ok got %0b exp 0", alloc_ok);
    end
    step();
    clear_inputs();
    checks++;
    if (free_count !== 7'd1 || head_ptr !== 7'd32) begin
      errors++;
      $display("FAIL one_free got cnt=%0d head=%0d exp 1/32", free_count, head_ptr);
    end
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_ok !== 1'b0) begin
      errors++;
      $display("FAIL one_free_dual got %0b exp 0", alloc_ok);
    end
    step();
    checks++;
    if (free_count !== 7'd1) begin
      errors++;
      $display("FAIL one_free_nocons got %0d exp 1", free_count);
    end
    alloc_req = 2'b10;
    #1;
    checks++;
    if (alloc_ok !== 1'b1 || alloc_addr[1] !== 6'd7) begin
      errors++;
      $display("FAIL slot1_only got ok=%0b addr=%0d exp ok=1 7", alloc_ok, alloc_addr[1]);
    end
    step();
    checks++;
    if (free_count !== 7'd0 || head_ptr !== 7'd33) begin
      errors++;
      $display("FAIL slot1_adv got cnt=%0d head=%0d exp 0/33", free_count, head_ptr);
    end
    clear_inputs();
  endtask

  task automatic test_recall();
    logic [6:0] ckpt;
    do_reset();
    alloc_req = 2'b11;
    repeat (2) step();
    ckpt = head_ptr;
    checks++;
    if (ckpt !== 7'd4) begin
      errors++;
      $display("FAIL ckpt_head got %0d exp 4", ckpt);
    end
    repeat (3) step();
    checks++;
    if (head_ptr !== 7'd10) begin
      errors++;
      $display("FAIL pre_recall got %0d exp 10", head_ptr);
    end
    if_recall    = 1'b1;
    recall_head  = 7'd4;
    free_valid   = 2'b01;
    free_addr[0] = 6'd5;
    step();
    clear_inputs();
    checks++;
    if (head_ptr !== 7'd4 || free_count !== 7'd29) begin
      errors++;
      $display("FAIL recall got head=%0d cnt=%0d exp 4/29", head_ptr, free_count);
    end
    alloc_req = 2'b01;
    #1;
    checks++;
    if (alloc_ok !== 1'b1 || alloc_addr[0] !== 6'd36) begin
      errors++;
      $display("FAIL post_recall got ok=%0b addr=%0d exp ok=1 36", alloc_ok, alloc_addr[0]);
    end
    clear_inputs();
  endtask

  task automatic test_stall_release();
    do_reset();
    alloc_req = 2'b11;
    ext_stall = 1'b1;
    step();
    checks++;
    if (head_ptr !== 7'd0 || free_count !== 7'd32) begin
      errors++;
      $display("FAIL stall_hold got head=%0d cnt=%0d exp 0/32", head_ptr, free_count);
    end
    clear_inputs();
    drain();
    alloc_req    = 2'b11;
    ext_stall    = 1'b1;
    free_valid   = 2'b11;
    free_addr[0] = 6'd10;
    free_addr[1] = 6'd11;
    step();
    clear_inputs();
    checks++;
    if (head_ptr !== 7'd32 || free_count !== 7'd2) begin
      errors++;
      $display("FAIL stall_rel got head=%0d cnt=%0d exp 32/2", head_ptr, free_count);
    end
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_ok !== 1'b1 || alloc_addr[0] !== 6'd10 || alloc_addr[1] !== 6'd11) begin
      errors++;
      $display("FAIL rel_order got ok=%0b %0d/%0d exp ok=1 10/11",
               alloc_ok, alloc_addr[0], alloc_addr[1]);
    end
    clear_inputs();
  endtask

  task automatic test_overflow();
    do_reset();
    drain();
    free_valid = 2'b11;
    for (int k = 0; k < 31; k++) begin
      free_addr[0] = 6'(2 * k);
      free_addr[1] = 6'(2 * k + 1);
      step();
    end
    free_valid   = 2'b01;
    free_addr[0] = 6'd62;
    step();
    checks++;
    if (free_count !== 7'd63 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL fill_63 got cnt=%0d err=%0b exp 63/0", free_count, overflow_err);
    end
    free_valid   = 2'b11;
    free_addr[0] = 6'd63;
    free_addr[1] = 6'd9;
    step();
    clear_inputs();
    checks++;
    if (free_count !== 7'd64 || overflow_err !== 1'b1 || head_ptr !== 7'd32) begin
      errors++;
      $display("FAIL full got cnt=%0d err=%0b head=%0d exp 64/1/32",
               free_count, overflow_err, head_ptr);
    end
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_ok !== 1'b1 || alloc_addr[0] !== 6'd0 || alloc_addr[1] !== 6'd1) begin
      errors++;
      $display("FAIL full_alloc got ok=%0b %0d/%0d exp ok=1 0/1",
               alloc_ok, alloc_addr[0], alloc_addr[1]);
    end
    alloc_req    = 2'b00;
    free_valid   = 2'b01;
    free_addr[0] = 6'd3;
    step();
    clear_inputs();
    checks++;
    if (free_count !== 7'd64 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL sticky got cnt=%0d err=%0b exp 64/1", free_count, overflow_err);
    end
    do_reset();
    checks++;
    if (free_count !== 7'd32 || overflow_err !== 1'b0 || head_ptr !== 7'd0) begin
      errors++;
      $display("FAIL reset_clear got cnt=%0d err=%0b head=%0d exp 32/0/0",
               free_count, overflow_err, head_ptr);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_drain();
    test_one_free();
    test_recall();
    test_stall_release();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
